// File: rtl/word_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : word_serializer_if                                         |
// | Description : Load handshake and serial output bundle for                |
// |               word_serializer.                                           |
// |               master : drives load_valid / Data_IN, observes the rest    |
// |               slave  : the serializer itself                             |
// |   load_valid   Data_IN holds a word to send                              |
// |   load_ready   serializer is idle and can accept a word                  |
// |   Data_IN      word to serialize (word_length bits)                      |
// |   serial_out   current serial bit                                        |
// |   serial_valid serial_out carries a frame bit this cycle                 |
// |   frame_start  first bit of a frame is on serial_out                     |
// |   done         one-cycle pulse after the last bit                        |
// |   busy         frame in progress                                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface word_serializer_if #(
  parameter int word_length = 4
);
  logic                   load_valid;
  logic                   load_ready;
  logic [word_length-1:0] Data_IN;
  logic                   serial_out;
  logic                   serial_valid;
  logic                   frame_start;
  logic                   done;
  logic                   busy;

  modport master (
    output load_valid,
    output Data_IN,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_start,
    input  done,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  Data_IN,
    output load_ready,
    output serial_out,
    output serial_valid,
    output frame_start,
    output done,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : word_serializer                                            |
// | Description : Parallel-in / serial-out drain. Captures a word on a       |
// |               valid/ready handshake and shifts it out one bit per clock, |
// |               then pulses done for one cycle before returning to idle.   |
// | Ports       : clk    rising-edge clock                                   |
// |               reset  synchronous active-high reset                       |
// |               bus    word_serializer_if.slave (handshake + serial side)  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module word_serializer #(
  parameter int word_length = 4,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  word_serializer_if.slave  bus
);

  localparam int c_cnt_w = (word_length > 1) ? $clog2(word_length) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(word_length - 1);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_shift = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [word_length-1:0] r_shift;
  logic [word_length-1:0] w_shift_next;
  logic [word_length-1:0] w_rot;
  logic [c_cnt_w-1:0]     r_count;
  logic [c_cnt_w-1:0]     w_count_next;
  logic                   r_serial_out;
  logic                   r_serial_valid;
  logic                   r_frame_start;
  logic                   r_done;
  logic                   w_serial_out_next;
  logic                   w_serial_valid_next;
  logic                   w_frame_start_next;
  logic                   w_done_next;
  logic                   w_accept;
  logic                   w_last;

  assign w_accept = bus.load_valid && (r_state == c_idle);
  assign w_last   = (r_count == c_last);

  // Rotating (instead of shifting) keeps the bit that is about to be sent at
  // the output end, so the next serial bit is read from the rotated value.
  assign w_rot = LSB_FIRST ? {r_shift[0], r_shift[word_length-1:1]}
                           : {r_shift[word_length-2:0], r_shift[word_length-1]};

  // State and datapath register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= c_idle;
      r_shift        <= '0;
      r_count        <= '0;
      r_serial_out   <= 1'b0;
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_shift        <= w_shift_next;
      r_count        <= w_count_next;
      r_serial_out   <= w_serial_out_next;
      r_serial_valid <= w_serial_valid_next;
      r_frame_start  <= w_frame_start_next;
      r_done         <= w_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (w_accept) w_state_next = c_shift;
      c_shift: if (w_last)   w_state_next = c_done;
      c_done:                w_state_next = c_idle;
      default:               w_state_next = c_idle;
    endcase
  end

  // Output logic: computes the values the registered outputs take next cycle,
  // so bit 0 is already on serial_out in the cycle right after the handshake.
  always_comb begin
    w_shift_next        = r_shift;
    w_count_next        = r_count;
    w_serial_out_next   = 1'b0;
    w_serial_valid_next = 1'b0;
    w_frame_start_next  = 1'b0;
    w_done_next         = 1'b0;
    case (r_state)
      c_idle: begin
        if (w_accept) begin
          w_shift_next        = bus.Data_IN;
          w_count_next        = '0;
          w_serial_out_next   = LSB_FIRST ? bus.Data_IN[0] : bus.Data_IN[word_length-1];
          w_serial_valid_next = 1'b1;
          w_frame_start_next  = 1'b1;
        end
      end
      c_shift: begin
        if (w_last) begin
          w_done_next = 1'b1;
        end else begin
          w_shift_next        = w_rot;
          w_count_next        = r_count + c_cnt_w'(1);
          w_serial_out_next   = LSB_FIRST ? w_rot[0] : w_rot[word_length-1];
          w_serial_valid_next = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.load_ready   = (r_state == c_idle);
  assign bus.busy         = (r_state == c_shift) || (r_state == c_done);
  assign bus.serial_out   = r_serial_out;
  assign bus.serial_valid = r_serial_valid;
  assign bus.frame_start  = r_frame_start;
  assign bus.done         = r_done;

endmodule
`default_nettype wire
